hpi_access_arbiter: RTL and testbench
=====================================

# hpi_access_arbiter

Sequences single-word transactions on the CY7C67200 OTG host port interface (HPI) and shares that port between two requesters: port 0 (CPU-side PIO bridge) and port 1 (hardware keycode poller). Each transaction drives programmable setup, strobe and hold phases on the active-low HPI strobes. A write transaction drives the data bus; a read transaction captures it. The block sits between the `nios_system` `otg_hpi_*` exports and the board HPI pins. The top level owns the tri-state buffer.

## Interface
- `SETUP_CYC`, default 1: cycles with CS_N low and address/data valid before the strobe. Legal range 1..15.
- `PULSE_CYC`, default 4: cycles the R_N/W_N strobe is held low. Legal range 1..15.
- `HOLD_CYC`, default 1: cycles after strobe release with CS_N still low. Legal range 1..15.
- `clk_clk` in, 1 bit: the single clock.
- `reset_reset_n` in, 1 bit: asynchronous, active-low reset.
- `req0`, `req1` in, 1 bit each: transaction request. Held high until the matching ack.
- `we0`, `we1` in, 1 bit each: 1 = write, 0 = read. Must be stable while req is high.
- `addr0`, `addr1` in, 2 bits each: HPI register address.
- `wdata0`, `wdata1` in, 16 bits each: write data.
- `ack0`, `ack1` out, 1 bit each: one-cycle completion pulse.
- `rdata` out, 16 bits: read data captured by the most recent read. Valid during ack and held afterwards.
- `hpi_addr` out, 2 bits: address to the HPI.
- `hpi_cs_n`, `hpi_r_n`, `hpi_w_n` out, 1 bit each: active-low HPI controls.
- `hpi_data_out` out, 16 bits: write data to the pad buffer.
- `hpi_data_oe` out, 1 bit: pad buffer output enable.
- `hpi_data_in` in, 16 bits: data from the pads.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE. A 4-bit phase counter runs within each state.
- **IDLE**
  - If any req is high: grant one port, latch its we/addr/wdata, load the counter with SETUP_CYC, go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP**
  - Drive CS_N low and hpi_addr.
  - For a write, also drive hpi_data_out and set hpi_data_oe = 1.
  - When the counter expires, go to STROBE.
- **STROBE**
  - Drive R_N low for a read, W_N low for a write.
  - For a read, register hpi_data_in into rdata on the last STROBE cycle.
  - Then go to HOLD.
- **HOLD**
  - Strobe high; CS_N, addr and data/oe unchanged.
  - Then go to DONE.
- **DONE**
  - CS_N high, oe = 0.
  - Pulse ack for the granted port, then go to IDLE.
- **Grant policy:** fixed priority to port 0 unless the round-robin option is compiled in (see Configuration).
- **Held request:** a req still high in the IDLE cycle after its ack starts a new transaction. Requesters deassert req in the cycle after ack to avoid a repeat.
- **Stability:** latched we/addr/wdata are immune to requester changes after the grant.
- **Reset values:** CS_N, R_N, W_N = 1; hpi_addr = 0; hpi_data_out = 0; hpi_data_oe = 0; rdata = 0; ack0 = ack1 = 0; state = IDLE; round-robin pointer = 1 (port 0 wins first).
- **Reset mid-transaction:** all strobes return high and oe drops immediately (asynchronous). No ack is issued. The requester reissues.

## Timing
- Cycle 0: IDLE samples req.
- Cycles 1..S: SETUP.
- Cycles S+1..S+P: STROBE.
- Next H cycles: HOLD.
- Cycle S+P+H+1: DONE, ack high.
- Defaults: CS_N low on cycles 1–6, strobe low on cycles 2–5, ack on cycle 7.
- Back-to-back throughput: one transaction per S+P+H+2 cycles (the mandatory IDLE cycle is included). Default is 8.
- R_N and W_N are never low together. A strobe is never low while CS_N is high.
- All outputs are registered. No combinational path from req to the HPI pins.

## Configuration
- **`HPI_ARB_ROUND_ROBIN_EN` defined:** when both reqs are high in IDLE, grant the port not granted last. The pointer updates at each grant.
- **`HPI_ARB_ROUND_ROBIN_EN` undefined:** port 0 always wins simultaneous requests. The pointer logic is absent. Port 1 can starve while port 0 holds req.

## Test plan
- **Reset:** assert reset_reset_n = 0 mid-STROBE of a write -> CS_N/W_N = 1 and oe = 0 in the same cycle, no ack, state IDLE after release.
- **Single write, defaults:** port 0, addr = 2, wdata = 0x1234 -> CS_N low cycles 1–6, W_N low cycles 2–5, hpi_data_out = 0x1234 with oe = 1 cycles 1–6, ack0 on cycle 7.
- **Single read:** port 1, addr = 0, hpi_data_in = 0xBEEF during STROBE -> R_N low cycles 2–5, W_N stays 1, rdata = 0xBEEF with ack1 on cycle 7, oe = 0 throughout.
- **Simultaneous requests with `HPI_ARB_ROUND_ROBIN_EN`:** req0 and req1 both held -> grants alternate 0, 1, 0, 1 at 8-cycle spacing.
- **Simultaneous requests without the macro:** same stimulus -> port 0 serviced repeatedly, ack1 never pulses.
- **Non-default parameters:** SETUP_CYC = 2, PULSE_CYC = 1, HOLD_CYC = 3 -> strobe low exactly cycle 3, ack on cycle 7. Requester changing wdata after grant does not alter hpi_data_out.

Source files
------------

// File: rtl/hpi_access_arbiter.sv
// Two-port arbiter and single-word sequencer for the CY7C67200 HPI.
// Define HPI_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority to port 0.
module hpi_access_arbiter #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_r_n,
    output logic        hpi_w_n,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        grant;
    logic        gsel;
    logic        last_cyc;
    logic        capture;

    logic        lat_port;
    logic        lat_we;
    logic [1:0]  lat_addr;
    logic [15:0] lat_wdata;
    logic        nx_port;
    logic        nx_we;
    logic [1:0]  nx_addr;
    logic [15:0] nx_wdata;

    logic        cs_n_d;
    logic        r_n_d;
    logic        w_n_d;
    logic        oe_d;
    logic        ack0_d;
    logic        ack1_d;
    logic [1:0]  addr_d;
    logic [15:0] dout_d;

`ifdef HPI_ARB_ROUND_ROBIN_EN
    // rr_last holds the port granted most recently; the other one wins a tie.
    logic        rr_last;

    always_comb begin
        gsel = req1 & (~req0 | ~rr_last);
    end
`else
    always_comb begin
        gsel = ~req0;
    end
`endif

    assign last_cyc = (cnt == 4'd1);
    assign capture  = (state == STROBE) && last_cyc && !lat_we;

    always_comb begin
        nx_port  = lat_port;
        nx_we    = lat_we;
        nx_addr  = lat_addr;
        nx_wdata = lat_wdata;
        if (grant) begin
            nx_port  = gsel;
            nx_we    = gsel ? we1 : we0;
            nx_addr  = gsel ? addr1 : addr0;
            nx_wdata = gsel ? wdata1 : wdata0;
        end
    end

    // State register with phase counter and latched transaction fields.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef HPI_ARB_ROUND_ROBIN_EN
            rr_last   <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_port  <= nx_port;
            lat_we    <= nx_we;
            lat_addr  <= nx_addr;
            lat_wdata <= nx_wdata;
`ifdef HPI_ARB_ROUND_ROBIN_EN
            if (grant) begin
                rr_last <= gsel;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (last_cyc) begin
                    state_nxt = STROBE;
                    cnt_nxt   = PULSE_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (last_cyc) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (last_cyc) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pin values are decoded from the next state so every pin is a flop output.
    always_comb begin
        cs_n_d = 1'b1;
        r_n_d  = 1'b1;
        w_n_d  = 1'b1;
        oe_d   = 1'b0;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        addr_d = hpi_addr;
        dout_d = hpi_data_out;
        unique case (state_nxt)
            SETUP, HOLD: begin
                cs_n_d = 1'b0;
                oe_d   = nx_we;
                addr_d = nx_addr;
                if (nx_we) begin
                    dout_d = nx_wdata;
                end
            end
            STROBE: begin
                cs_n_d = 1'b0;
                r_n_d  = nx_we;
                w_n_d  = ~nx_we;
                oe_d   = nx_we;
                addr_d = nx_addr;
                if (nx_we) begin
                    dout_d = nx_wdata;
                end
            end
            DONE: begin
                ack0_d = ~nx_port;
                ack1_d = nx_port;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hpi_cs_n     <= 1'b1;
            hpi_r_n      <= 1'b1;
            hpi_w_n      <= 1'b1;
            hpi_data_oe  <= 1'b0;
            hpi_addr     <= '0;
            hpi_data_out <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata        <= '0;
        end else begin
            hpi_cs_n     <= cs_n_d;
            hpi_r_n      <= r_n_d;
            hpi_w_n      <= w_n_d;
            hpi_data_oe  <= oe_d;
            hpi_addr     <= addr_d;
            hpi_data_out <= dout_d;
            ack0         <= ack0_d;
            ack1         <= ack1_d;
            if (capture) begin
                rdata <= hpi_data_in;
            end
        end
    end

endmodule

// File: tb/tb_hpi_access_arbiter.sv
// Bench for hpi_access_arbiter: vector table, hand sequences, and a
// randomized run against a transaction-level timing model.
`timescale 1ns/1ps
module tb_hpi_access_arbiter;

    localparam int S = 1;
    localparam int P = 4;
    localparam int H = 1;
    localparam int T = S + P + H + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [1:0]  addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0, hpi_data_in = 0;
    logic        ack0, ack1, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe;
    logic [15:0] rdata, hpi_data_out;
    logic [1:0]  hpi_addr;

    logic        req0b = 0, we0b = 0;
    logic [1:0]  addr0b = 0;
    logic [15:0] wdata0b = 0;
    logic        ack0b, ack1b, cs_nb, r_nb, w_nb, oeb;
    logic [15:0] rdatab, doutb;
    logic [1:0]  haddrb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hpi_access_arbiter dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .hpi_addr(hpi_addr),
        .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
        .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
        .hpi_data_in(hpi_data_in)
    );

    hpi_access_arbiter #(.SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(3)) dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .req0(req0b), .req1(1'b0), .we0(we0b), .we1(1'b0),
        .addr0(addr0b), .addr1(2'd0), .wdata0(wdata0b), .wdata1(16'h0),
        .ack0(ack0b), .ack1(ack1b), .rdata(rdatab), .hpi_addr(haddrb),
        .hpi_cs_n(cs_nb), .hpi_r_n(r_nb), .hpi_w_n(w_nb),
        .hpi_data_out(doutb), .hpi_data_oe(oeb),
        .hpi_data_in(16'h0)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] din;
        int          cs_first;
        int          cs_last;
        int          stb_first;
        int          stb_last;
        int          ack_cyc;
        logic [15:0] rdata;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_port(input bit p, input bit r, input bit w,
                              input logic [1:0] a, input logic [15:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 0; req1 = 0; req0b = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cs_f = -1, cs_l = -1, st_f = -1, st_l = -1, ack_c = -1;
        int wrong = 0, oe_bad = 0;
        logic [15:0] rd = 16'hxxxx, d1 = 16'hxxxx;
        logic [1:0]  a1 = 2'bxx;
        @(negedge clk);
        hpi_data_in = v.din;
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!hpi_cs_n) begin
                if (cs_f < 0) cs_f = k;
                cs_l = k;
            end
            if ((v.we ? hpi_w_n : hpi_r_n) == 1'b0) begin
                if (st_f < 0) st_f = k;
                st_l = k;
            end
            if ((v.we ? hpi_r_n : hpi_w_n) == 1'b0) wrong++;
            if (hpi_data_oe !== (v.we && !hpi_cs_n)) oe_bad++;
            if (k == 1) begin
                a1 = hpi_addr;
                d1 = hpi_data_out;
            end
            if (v.port ? ack0 : ack1) wrong++;
            if ((v.port ? ack1 : ack0) && ack_c < 0) begin
                ack_c = k;
                rd = rdata;
                drive_port(v.port, 1'b0, v.we, v.addr, v.wdata);
            end
        end
        drive_port(v.port, 1'b0, v.we, v.addr, v.wdata);
        check($sformatf("vec%0d cs_first", idx), 64'(cs_f), 64'(v.cs_first));
        check($sformatf("vec%0d cs_last", idx), 64'(cs_l), 64'(v.cs_last));
        check($sformatf("vec%0d stb_first", idx), 64'(st_f), 64'(v.stb_first));
        check($sformatf("vec%0d stb_last", idx), 64'(st_l), 64'(v.stb_last));
        check($sformatf("vec%0d ack_cyc", idx), 64'(ack_c), 64'(v.ack_cyc));
        check($sformatf("vec%0d rdata", idx), 64'(rd), 64'(v.rdata));
        check($sformatf("vec%0d dout", idx), 64'(d1), 64'(v.dout));
        check($sformatf("vec%0d addr", idx), 64'(a1), 64'(v.addr));
        check($sformatf("vec%0d wrong_strobe_or_ack", idx), 64'(wrong), 64'(0));
        check($sformatf("vec%0d oe", idx), 64'(oe_bad), 64'(0));
    endtask

    task automatic run_reset_mid();
        int seen_ack = 0, seen_cs = 0;
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 2'd3, 16'hCAFE);
        repeat (3) @(negedge clk);
        check("rst_pre_w_n", 64'(hpi_w_n), 64'(0));
        #1;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        check("rst_cs_n", 64'(hpi_cs_n), 64'(1));
        check("rst_w_n", 64'(hpi_w_n), 64'(1));
        check("rst_oe", 64'(hpi_data_oe), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack0 || ack1) seen_ack++;
            if (!hpi_cs_n) seen_cs++;
        end
        check("rst_no_ack", 64'(seen_ack), 64'(0));
        check("rst_idle", 64'(seen_cs), 64'(0));
    endtask

    task automatic run_simul();
        int got_p[4] = '{-1, -1, -1, -1};
        int got_c[4] = '{-1, -1, -1, -1};
        int exp_p[4];
        int n = 0;
`ifdef HPI_ARB_ROUND_ROBIN_EN
        exp_p = '{0, 1, 0, 1};
`else
        exp_p = '{0, 0, 0, 0};
`endif
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 2'd1, 16'h0101);
        drive_port(1'b1, 1'b1, 1'b0, 2'd2, 16'h0202);
        for (int k = 1; k <= 40 && n < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                got_p[n] = ack1 ? 1 : 0;
                got_c[n] = k;
                n++;
                if (n == 4) begin
                    req0 = 0;
                    req1 = 0;
                end
            end
        end
        req0 = 0;
        req1 = 0;
        check("simul_count", 64'(n), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("simul_port%0d", i), 64'(got_p[i]), 64'(exp_p[i]));
            check($sformatf("simul_cyc%0d", i), 64'(got_c[i]), 64'(7 + 8 * i));
        end
    endtask

    task automatic run_dut2();
        int cs_f = -1, cs_l = -1, st_f = -1, st_l = -1, ack_c = -1;
        int dbad = 0;
        @(negedge clk);
        req0b = 1; we0b = 1; addr0b = 2'd1; wdata0b = 16'h1111;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) wdata0b = 16'hFFFF;
            if (!cs_nb) begin
                if (cs_f < 0) cs_f = k;
                cs_l = k;
                if (doutb !== 16'h1111) dbad++;
            end
            if (!w_nb) begin
                if (st_f < 0) st_f = k;
                st_l = k;
            end
            if (ack0b && ack_c < 0) begin
                ack_c = k;
                req0b = 0;
            end
        end
        req0b = 0;
        check("p2_cs_first", 64'(cs_f), 64'(1));
        check("p2_cs_last", 64'(cs_l), 64'(6));
        check("p2_stb_first", 64'(st_f), 64'(3));
        check("p2_stb_last", 64'(st_l), 64'(3));
        check("p2_ack_cyc", 64'(ack_c), 64'(7));
        check("p2_dout_stable", 64'(dbad), 64'(0));
    endtask

    task automatic run_random(input int ncyc);
        bit act = 0, a_port = 0, a_we = 0, last = 1, pick, stb, e_cs;
        int t0 = 0, ph;
        logic [1:0]  a_addr = 0, e_addr = 0;
        logic [15:0] a_wdata = 0, cap = 0, e_dout = 0, e_rdata = 0;
        logic [39:0] exp_v, got_v;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (act && c - t0 >= T) act = 0;
            ph = act ? c - t0 : -1;
            if (ph == 1) begin
                e_addr = a_addr;
                if (a_we) e_dout = a_wdata;
            end
            if (ph == S + P + 1 && !a_we) e_rdata = cap;
            stb  = act && ph >= S + 1 && ph <= S + P;
            e_cs = !(act && ph >= 1 && ph <= S + P + H);
            exp_v = {ph == S + P + H + 1 && !a_port,
                     ph == S + P + H + 1 && a_port,
                     e_cs, !(stb && !a_we), !(stb && a_we),
                     !e_cs && a_we, e_addr, e_dout, e_rdata};
            got_v = {ack0, ack1, hpi_cs_n, hpi_r_n, hpi_w_n,
                     hpi_data_oe, hpi_addr, hpi_data_out, rdata};
            check($sformatf("rand_c%0d", c), 64'(got_v), 64'(exp_v));
            if (ph == S + P + H + 1 && $urandom_range(3) != 0) begin
                if (a_port) req1 = 0;
                else req0 = 0;
            end
            if (!req0 && $urandom_range(3) == 0) begin
                drive_port(1'b0, 1'b1, 1'($urandom), 2'($urandom), 16'($urandom));
            end
            if (!req1 && $urandom_range(3) == 0) begin
                drive_port(1'b1, 1'b1, 1'($urandom), 2'($urandom), 16'($urandom));
            end
            hpi_data_in = 16'($urandom);
            if (ph == S + P) cap = hpi_data_in;
            if (!act && (req0 || req1)) begin
`ifdef HPI_ARB_ROUND_ROBIN_EN
                pick = req1 && (!req0 || !last);
`else
                pick = !req0;
`endif
                act     = 1;
                t0      = c;
                a_port  = pick;
                a_we    = pick ? we1 : we0;
                a_addr  = pick ? addr1 : addr0;
                a_wdata = pick ? wdata1 : wdata0;
                last    = pick;
            end
        end
        req0 = 0;
        req1 = 0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 2'd2, 16'h1234, 16'h5555, 1, 6, 2, 5, 7, 16'h0000, 16'h1234};
        tbl[1] = '{1'b1, 1'b0, 2'd0, 16'h7777, 16'hBEEF, 1, 6, 2, 5, 7, 16'hBEEF, 16'h1234};
        tbl[2] = '{1'b0, 1'b0, 2'd3, 16'h0000, 16'h0F0F, 1, 6, 2, 5, 7, 16'h0F0F, 16'h1234};
        tbl[3] = '{1'b1, 1'b1, 2'd1, 16'hA5A5, 16'h3C3C, 1, 6, 2, 5, 7, 16'h0F0F, 16'hA5A5};

        #2;
        rst_n = 1'b0;
        #20;
        check("reset_pins", 64'({hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe}), 64'(4'b1110));
        check("reset_ack", 64'({ack0, ack1}), 64'(0));
        check("reset_addr", 64'(hpi_addr), 64'(0));
        check("reset_dout", 64'(hpi_data_out), 64'(0));
        check("reset_rdata", 64'(rdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_vec(i, tbl[i]);
        end

        run_reset_mid();
        run_simul();
        run_dut2();

        do_reset();
        run_random(800);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
